// File: rtl/i2s_adc_rx_if.sv
// Stereo sample stream from the I2S receiver to the audio mixer.
interface i2s_adc_rx_if;
  logic [15:0] snd_l;
  logic [15:0] snd_r;
  logic        out_vld;
  logic        out_rdy;

  modport master (output snd_l, snd_r, out_vld, input out_rdy);
  modport slave  (input snd_l, snd_r, out_vld, output out_rdy);
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S receiver: deserialises 16-bit stereo pairs from an external ADC into
// the clk domain, with lock tracking, bit-clock timeout and overrun reporting.
module i2s_adc_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SLOT_MAX    = 32,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i2s_sclk,
  input  logic         i2s_lrck,
  input  logic         i2s_sdin,
  input  logic         ovr_clr,
  i2s_adc_rx_if.master bus,
  output logic         locked,
  output logic         overrun,
  output logic         frame_err,
  output logic [5:0]   slot_len
);

  localparam int unsigned CNT_W  = $clog2(SLOT_MAX + 3);
  localparam int unsigned SH_W   = $clog2(SLOT_MAX);
  localparam int unsigned LOCK_W = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic                   sclk_s;
  logic                   lrck_s;
  logic                   sdin_s;

  logic                   sclk_prev;
  logic                   lrck_prev;
  logic [SLOT_MAX-1:0]    sr;
  logic [CNT_W-1:0]       cnt;
  logic                   started;
  logic                   left_present;
  logic                   left_ok;
  logic [CNT_W-1:0]       left_len;
  logic [15:0]            left_word;
  logic [LOCK_W-1:0]      lock_cnt;
  logic                   prev_valid;
  logic [CNT_W-1:0]       prev_len;
  logic [TMO_W-1:0]       tmo_cnt;

  logic                   rise_c;
  logic                   change_c;
  logic                   tmo_c;
  logic [SLOT_MAX-1:0]    sr_nxt_c;
  logic [CNT_W-1:0]       len_c;
  logic [SH_W-1:0]        sh_c;
  logic [15:0]            word_c;
  logic                   slot_ok_c;
  logic                   eval_c;
  logic                   frame_ok_c;
  logic [LOCK_W-1:0]      lock_nxt_c;
  logic                   publish_c;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign lrck_s = lrck_sync[SYNC_STAGES-1];
  assign sdin_s = sdin_sync[SYNC_STAGES-1];

  // Input synchronisers; equal depth keeps data and word select aligned to sclk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      lrck_sync <= '0;
      sdin_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], i2s_sdin};
      sclk_prev <= sclk_s;
    end
  end

  // Slot length, word capture and frame verdict for the current sclk rise.
  always_comb begin
    rise_c     = sclk_s & ~sclk_prev;
    change_c   = rise_c & (lrck_s ^ lrck_prev);
    sr_nxt_c   = {sr[SLOT_MAX-2:0], sdin_s};
    len_c      = cnt + CNT_W'(1);
    slot_ok_c  = (len_c >= CNT_W'(16)) && (len_c <= CNT_W'(SLOT_MAX));
    sh_c       = slot_ok_c ? SH_W'(len_c - CNT_W'(16)) : '0;
    word_c     = sr_nxt_c[sh_c +: 16];
    tmo_c      = ~rise_c && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    eval_c     = change_c & started & ~lrck_s & left_present;
    frame_ok_c = slot_ok_c & left_ok & (len_c == left_len) &
                 (~prev_valid | (len_c == prev_len));
    lock_nxt_c = (lock_cnt == LOCK_W'(LOCK_FRAMES)) ? lock_cnt : lock_cnt + LOCK_W'(1);
    publish_c  = eval_c & frame_ok_c & (lock_nxt_c == LOCK_W'(LOCK_FRAMES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (rise_c) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Slot framing and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      lrck_prev    <= 1'b0;
      sr           <= '0;
      cnt          <= '0;
      started      <= 1'b0;
      left_present <= 1'b0;
      left_ok      <= 1'b0;
      left_len     <= '0;
      left_word    <= '0;
      lock_cnt     <= '0;
      prev_valid   <= 1'b0;
      prev_len     <= '0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
      slot_len     <= '0;
    end else begin
      frame_err <= 1'b0;
      if (tmo_c) begin
        sr           <= '0;
        cnt          <= '0;
        started      <= 1'b0;
        left_present <= 1'b0;
        lock_cnt     <= '0;
        prev_valid   <= 1'b0;
        locked       <= 1'b0;
      end else if (rise_c) begin
        sr        <= sr_nxt_c;
        lrck_prev <= lrck_s;
        if (!change_c) begin
          if (cnt != CNT_W'(SLOT_MAX + 1)) cnt <= cnt + CNT_W'(1);
        end else begin
          cnt     <= '0;
          started <= 1'b1;
          // The slot ending at the first change is of unknown start: dropped.
          if (started && lrck_s) begin
            left_present <= 1'b1;
            left_ok      <= slot_ok_c;
            left_len     <= len_c;
            left_word    <= word_c;
          end
          if (eval_c) begin
            left_present <= 1'b0;
            if (frame_ok_c) begin
              lock_cnt   <= lock_nxt_c;
              prev_valid <= 1'b1;
              prev_len   <= len_c;
              if (lock_nxt_c == LOCK_W'(LOCK_FRAMES)) begin
                locked   <= 1'b1;
                slot_len <= 6'(len_c);
              end
            end else begin
              frame_err  <= 1'b1;
              lock_cnt   <= '0;
              prev_valid <= 1'b0;
              locked     <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Output pair register and valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.snd_l   <= '0;
      bus.snd_r   <= '0;
      bus.out_vld <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (publish_c) begin
        bus.snd_l   <= left_word;
        bus.snd_r   <= word_c;
        bus.out_vld <= 1'b1;
      end else if (bus.out_vld && bus.out_rdy) begin
        bus.out_vld <= 1'b0;
      end
      if (publish_c && bus.out_vld && !bus.out_rdy) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: random I2S slot streams against a slot-level model.
module tb_i2s_adc_rx;

  localparam int unsigned SLOT_MAX    = 32;
  localparam int unsigned LOCK_FRAMES = 4;
  localparam int unsigned TIMEOUT     = 256;
  localparam int unsigned HALF        = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       lrck;
  logic       sdin;
  logic       ovr_clr;
  logic       locked;
  logic       overrun;
  logic       frame_err;
  logic [5:0] slot_len;

  i2s_adc_rx_if bus();

  i2s_adc_rx #(
    .SYNC_STAGES(2),
    .SLOT_MAX   (SLOT_MAX),
    .LOCK_FRAMES(LOCK_FRAMES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i2s_sclk (sclk),
    .i2s_lrck (lrck),
    .i2s_sdin (sdin),
    .ovr_clr  (ovr_clr),
    .bus      (bus),
    .locked   (locked),
    .overrun  (overrun),
    .frame_err(frame_err),
    .slot_len (slot_len)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Slot-level reference model state.
  bit          m_started;
  bit          m_have_left;
  int          m_left_len;
  logic [15:0] m_left_word;
  int          m_lock;
  int          m_prev_len;
  int          exp_locked;
  int          exp_slot_len;
  int          exp_err;
  logic [31:0] exp_pairs[$];

  // Observations from the output port.
  bit          mon_en;
  int          obs_err;
  logic [31:0] obs_pairs[$];

  int exp_base, obs_base, err_base, exp_err_base;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bus.out_vld && bus.out_rdy) obs_pairs.push_back({bus.snd_l, bus.snd_r});
      if (frame_err) obs_err++;
    end
  end

  task automatic model_clear(input bit keep_len);
    m_started   = 0;
    m_have_left = 0;
    m_lock      = 0;
    m_prev_len  = -1;
    exp_locked  = 0;
    if (!keep_len) exp_slot_len = 0;
  endtask

  // One complete channel slot as seen on the wire.
  task automatic model_slot(input logic ch, input int len, input logic [15:0] word);
    bit good;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (ch == 1'b0) begin
      m_have_left = 1;
      m_left_len  = len;
      m_left_word = word;
    end else if (m_have_left) begin
      m_have_left = 0;
      good = (m_left_len >= 16) && (m_left_len <= int'(SLOT_MAX)) &&
             (len >= 16) && (len <= int'(SLOT_MAX)) && (m_left_len == len) &&
             (m_prev_len < 0 || m_prev_len == len);
      if (!good) begin
        exp_err++;
        m_lock     = 0;
        m_prev_len = -1;
        exp_locked = 0;
      end else begin
        m_prev_len = len;
        if (m_lock < int'(LOCK_FRAMES)) m_lock++;
        if (m_lock == int'(LOCK_FRAMES)) begin
          exp_locked   = 1;
          exp_slot_len = len;
          exp_pairs.push_back({m_left_word, word});
        end
      end
    end
  endtask

  task automatic drive_bit(input logic d, input logic ws);
    @(negedge clk);
    sclk = 1'b0;
    sdin = d;
    lrck = ws;
    repeat (HALF - 1) @(negedge clk);
    @(negedge clk);
    sclk = 1'b1;
    repeat (HALF - 1) @(negedge clk);
  endtask

  // Word select flips on the LSB, one bit ahead of the next channel's MSB.
  task automatic send_word(input logic ch, input int len, input logic [15:0] sample);
    logic b;
    for (int j = 0; j < len; j++) begin
      b = (j < 16) ? sample[15 - j] : 1'($urandom);
      drive_bit(b, (j == len - 1) ? ~ch : ch);
    end
    model_slot(ch, len, sample);
  endtask

  task automatic send_partial(input logic ch, input int nbits);
    for (int j = 0; j < nbits; j++) drive_bit(1'($urandom), ch);
  endtask

  task automatic send_frame(input int len_l, input int len_r,
                            input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, len_l, l);
    send_word(1'b1, len_r, r);
  endtask

  task automatic rand_frames(input int n, input int len);
    for (int k = 0; k < n; k++) send_frame(len, len, 16'($urandom), 16'($urandom));
  endtask

  task automatic mark();
    exp_base     = exp_pairs.size();
    obs_base     = obs_pairs.size();
    err_base     = obs_err;
    exp_err_base = exp_err;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic check_scn(input string tag);
    int n_obs, n_exp;
    settle();
    n_obs = obs_pairs.size() - obs_base;
    n_exp = exp_pairs.size() - exp_base;
    check({tag, " pairs"}, n_obs, n_exp);
    for (int i = 0; i < n_exp && i < n_obs; i++)
      check({tag, " pair"}, int'(obs_pairs[obs_base + i]), int'(exp_pairs[exp_base + i]));
    check({tag, " frame_err"}, obs_err - err_base, exp_err - exp_err_base);
    check({tag, " locked"}, int'(locked), exp_locked);
    check({tag, " slot_len"}, int'(slot_len), exp_slot_len);
    mark();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    sclk = 1'b0;
    lrck = 1'b0;
    sdin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear(0);
    mark();
  endtask

  logic [31:0] last;

  initial begin
    rst         = 1'b1;
    sclk        = 1'b0;
    lrck        = 1'b0;
    sdin        = 1'b0;
    ovr_clr     = 1'b0;
    bus.out_rdy = 1'b1;
    mon_en      = 1'b1;
    obs_err     = 0;
    exp_err     = 0;
    exp_slot_len = 0;
    model_clear(0);
    do_reset();

    check("rst snd_l", int'(bus.snd_l), 0);
    check("rst snd_r", int'(bus.snd_r), 0);
    check("rst out_vld", int'(bus.out_vld), 0);
    check("rst locked", int'(locked), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst slot_len", int'(slot_len), 0);

    // Fixed pattern from a cold start, then random 32-bit data.
    for (int k = 0; k < 6; k++) send_frame(32, 32, 16'h1234, 16'hABCD);
    check_scn("s32 fixed");
    rand_frames(4, 32);
    check_scn("s32 rand");

    // 16-bit slots with full-scale signed extremes.
    do_reset();
    for (int k = 0; k < 6; k++) send_frame(16, 16, 16'h8000, 16'h7FFF);
    check_scn("s16");
    check("s16 signed", int'($signed(bus.snd_l)), -32768);

    // Length change while locked: one bad frame, then relock.
    rand_frames(5, 32);
    check_scn("s16 to s32");
    for (int k = 0; k < 5; k++) send_frame(24, 24, 16'h0F0F, 16'($urandom));
    check_scn("s24");

    // Consumer stalls across two frames.
    mon_en = 1'b0;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    rand_frames(2, 24);
    settle();
    last = exp_pairs[$];
    check("ovr overrun", int'(overrun), 1);
    check("ovr out_vld", int'(bus.out_vld), 1);
    check("ovr data", int'({bus.snd_l, bus.snd_r}), int'(last));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr clear", int'(overrun), 0);
    check("ovr vld held", int'(bus.out_vld), 1);
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check("ovr accept", int'(bus.out_vld), 0);
    mon_en = 1'b1;
    mark();

    // sclk stops: lock drops silently, data held, then relock.
    repeat (200) @(negedge clk);
    check("tmo early", int'(locked), 1);
    repeat (100) @(negedge clk);
    check("tmo locked", int'(locked), 0);
    check("tmo frame_err", obs_err - err_base, 0);
    check("tmo data held", int'({bus.snd_l, bus.snd_r}), int'(last));
    model_clear(1);
    mark();
    rand_frames(6, 32);
    check_scn("tmo relock");

    // Reset in the middle of a right slot, then bad slot lengths.
    send_word(1'b0, 32, 16'($urandom));
    send_partial(1'b1, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst out_vld", int'(bus.out_vld), 0);
    check("mid rst locked", int'(locked), 0);
    check("mid rst snd", int'({bus.snd_l, bus.snd_r}), 0);
    check("mid rst slot_len", int'(slot_len), 0);
    sclk = 1'b0;
    lrck = 1'b0;
    sdin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear(0);
    mark();
    send_word(1'b0, 32, 16'($urandom));
    send_frame(17, 40, 16'($urandom), 16'($urandom));
    send_frame(40, 40, 16'($urandom), 16'($urandom));
    send_frame(20, 20, 16'($urandom), 16'($urandom));
    check_scn("bad len");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
